mdr_cmd_driver: RTL and testbench
=================================

Name: mdr_cmd_driver

Overview:
Initiator side of the MDR (multiply/divide/root) operand protocol. Accepts one command (op, X, Y) from an upstream valid/ready source and sequences the MDR start and load strobes. It waits for the MDR to report ready or error, captures the result and remainder, and returns a single response beat downstream. One command is in flight at a time.

Parameters:
DW, 16, operand/result width; must match data_t in pkg_system_mdr.
TO_CYC, 1024, watchdog limit in cycles spent in WAIT_DONE. Used only with the optional feature.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  driver can accept a command
cmd_op  in  op_t(2)  MULT=2'b00, DIV=2'b01, SQRT=2'b10, 2'b11 reserved
cmd_x  in  DW  operand X
cmd_y  in  DW  operand Y; ignored for SQRT, driven as 0
w_start  out  1  MDR start pulse
w_load  out  1  MDR load strobe
w_op  out  op_t  operation to MDR
w_dataIn_X  out  DW  operand X bus
w_dataIn_Y  out  DW  operand Y bus
w_ready  in  1  MDR done (level)
w_error  in  1  MDR operand error (pulse or level)
w_ovf  in  1  MDR overflow flag, sampled together with w_ready
mdr_result  in  DW  MDR primary result
mdr_rem  in  DW  MDR remainder
rsp_valid  out  1  response available
rsp_ready  in  1  downstream accepts response
rsp_result  out  DW  captured result
rsp_rem  out  DW  captured remainder
rsp_status  out  2  00 OK, 01 ERROR, 10 OVERFLOW, 11 TIMEOUT/BADOP

Behaviour:
- Reset (async, rst=1) forces state IDLE and sets every output to 0: cmd_ready, w_start, w_load, w_op, w_dataIn_X/Y, rsp_valid, rsp_result, rsp_rem, rsp_status. The first cmd_ready=1 appears on the first clk edge after rst deasserts.
- Reset during any state aborts the command. No response is produced.
- FSM states, with all outputs registered:
  - IDLE: cmd_ready=1. When cmd_valid&cmd_ready, latch op/x/y. Reserved op (2'b11) -> RESP with status 11 and result/rem=0; MDR is not touched. Otherwise -> START.
  - START: w_start=1 for exactly 1 cycle, w_op valid -> LOAD_X.
  - LOAD_X: w_dataIn_X valid, w_load=1 for 1 cycle -> GAP.
  - GAP: w_load=0 for 1 cycle -> LOAD_Y.
  - LOAD_Y: w_dataIn_Y valid (0 for SQRT), w_load=1 for 1 cycle -> WAIT_DONE.
  - WAIT_DONE: all strobes 0. Leaves on the first of:
    - w_error=1 -> RESP with status 01.
    - w_ready=1 -> capture mdr_result/mdr_rem, status 10 if w_ovf else 00 -> RESP.
    - If w_error and w_ready are high in the same cycle, error wins.
  - RESP: rsp_valid=1 with outputs held stable until rsp_ready. On the handshake cycle -> IDLE, rsp_valid=0 next cycle.
- w_op, w_dataIn_X and w_dataIn_Y hold their latched values from START through WAIT_DONE. They return to 0 in IDLE.
- w_error is ignored outside WAIT_DONE. w_ready is ignored in START through LOAD_Y.
- Latency: command accept to first WAIT_DONE cycle = 4 cycles (START, LOAD_X, GAP, LOAD_Y). Best-case throughput is one command per (5 + MDR latency + 1) cycles.
- cmd_ready is 0 in every state except IDLE, so there is no back-to-back accept.

Optional Feature:
MDR_TIMEOUT_EN
- Defined: a counter of $clog2(TO_CYC+1) bits clears on entry to WAIT_DONE and increments each cycle there. When it reaches TO_CYC-1 with neither w_ready nor w_error seen, the FSM goes to RESP with status 11, result/rem=0, and a 1-cycle w_start pulse to re-arm the MDR. w_ready or w_error arriving in the same cycle as the limit takes priority over the timeout.
- Undefined: there is no counter, and WAIT_DONE waits indefinitely.

Decomposition:
- pkg_system_mdr gains:
  - drv_state_t enum.
  - rsp_status_t (OK, ERROR, OVF, TIMEOUT).
  - localparam op encodings MULT/DIV/SQRT and OP_RSVD.
  - Reuses data_t and op_t.
- One natural sub-module: mdr_drv_watchdog, the timeout counter, instantiated only under MDR_TIMEOUT_EN.

Test Plan:
- MULT x=16'd7 y=16'd9, MDR model returns 63 after 5 cycles -> w_start at T+1, w_load at T+2 and T+4, rsp_result=63, rsp_status=00.
- DIV x=100 y=7 -> rsp_result=14, rsp_rem=2, status 00. With rsp_ready held low 3 cycles, outputs stay stable and cmd_ready stays 0.
- DIV y=0, model pulses w_error and w_ready in the same cycle -> status 01, no capture of mdr_result.
- cmd_op=2'b11 -> no w_start or w_load ever, rsp_status=11 on the cycle after accept.
- rst asserted mid WAIT_DONE -> all outputs 0 asynchronously; the next command completes normally.
- MDR_TIMEOUT_EN with TO_CYC=8 and the model never ready -> status 11 exactly 8 cycles after entering WAIT_DONE, plus a w_start re-arm pulse.

Source files
------------

// File: rtl/pkg_system_mdr.sv
// Shared types for the MDR (multiply/divide/root) subsystem.
//   data_t        : operand/result word
//   op_t          : MDR operation code
//   drv_state_t   : command driver FSM state
//   rsp_status_t  : response status returned downstream
package pkg_system_mdr;

  localparam int DATA_WIDTH = 16;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [1:0]            op_t;

  localparam op_t MULT    = 2'b00;
  localparam op_t DIV     = 2'b01;
  localparam op_t SQRT    = 2'b10;
  localparam op_t OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_ERROR   = 2'b01,
    RSP_OVF     = 2'b10,
    RSP_TIMEOUT = 2'b11   // also reported for the reserved opcode
  } rsp_status_t;

  typedef enum logic [2:0] {
    DRV_IDLE      = 3'd0,
    DRV_START     = 3'd1,
    DRV_LOAD_X    = 3'd2,
    DRV_GAP       = 3'd3,
    DRV_LOAD_Y    = 3'd4,
    DRV_WAIT_DONE = 3'd5,
    DRV_RESP      = 3'd6
  } drv_state_t;

endpackage

// File: rtl/mdr_cmd_driver_if.sv
// Bus bundle of the MDR command driver: upstream command handshake,
// MDR operand/strobe bus and downstream response handshake.
//   modport master : the driver itself
//   modport slave  : the environment around the driver (source, MDR, sink)
interface mdr_cmd_driver_if #(
  parameter int DW = 16
);
  import pkg_system_mdr::*;

  // upstream command
  logic          cmd_valid;
  logic          cmd_ready;
  op_t           cmd_op;
  logic [DW-1:0] cmd_x;
  logic [DW-1:0] cmd_y;

  // MDR operand bus
  logic          w_start;
  logic          w_load;
  op_t           w_op;
  logic [DW-1:0] w_dataIn_X;
  logic [DW-1:0] w_dataIn_Y;
  logic          w_ready;
  logic          w_error;
  logic          w_ovf;
  logic [DW-1:0] mdr_result;
  logic [DW-1:0] mdr_rem;

  // downstream response
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic [DW-1:0] rsp_rem;
  logic [1:0]    rsp_status;

  modport master (
    input  cmd_valid, cmd_op, cmd_x, cmd_y,
    input  w_ready, w_error, w_ovf, mdr_result, mdr_rem,
    input  rsp_ready,
    output cmd_ready,
    output w_start, w_load, w_op, w_dataIn_X, w_dataIn_Y,
    output rsp_valid, rsp_result, rsp_rem, rsp_status
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_x, cmd_y,
    output w_ready, w_error, w_ovf, mdr_result, mdr_rem,
    output rsp_ready,
    input  cmd_ready,
    input  w_start, w_load, w_op, w_dataIn_X, w_dataIn_Y,
    input  rsp_valid, rsp_result, rsp_rem, rsp_status
  );

endinterface

// File: rtl/mdr_drv_watchdog.sv
// WAIT_DONE watchdog for the MDR command driver (built only with
// MDR_TIMEOUT_EN).
//   clk, rst : clock, asynchronous active-high reset
//   in_wait  : driver is in WAIT_DONE this cycle
//   expired  : this is the TO_CYC-th consecutive WAIT_DONE cycle
module mdr_drv_watchdog #(
  parameter int TO_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  output logic expired
);

  localparam int CW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt_q;

  // Held at zero outside WAIT_DONE so the first WAIT_DONE cycle sees 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!in_wait) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = in_wait && (cnt_q == LIMIT);

endmodule

// File: rtl/mdr_cmd_driver.sv
// MDR command driver: accepts one (op, X, Y) command, sequences the MDR
// start/load strobes, waits for ready/error and returns one response beat.
// One command in flight; every output is registered.
//
// Ports (clk, rst plus the mdr_cmd_driver_if master modport):
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_valid/ready   : upstream command handshake, cmd_op/cmd_x/cmd_y payload
//   w_start, w_load   : MDR start pulse and operand load strobe
//   w_op, w_dataIn_X/Y: operation and operands, held START..WAIT_DONE
//   w_ready/error/ovf : MDR completion, operand error, overflow
//   mdr_result/rem    : MDR outputs, captured on w_ready
//   rsp_*             : downstream response handshake and payload
//
// Build option: define MDR_TIMEOUT_EN to add the WAIT_DONE watchdog
// (TO_CYC cycles); a timeout returns status 11 and re-arms the MDR with
// a one-cycle w_start.
module mdr_cmd_driver
  import pkg_system_mdr::*;
#(
  parameter int DW     = 16,
  parameter int TO_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  mdr_cmd_driver_if.master    bus
);

  localparam logic [2:0] ST_IDLE   = DRV_IDLE;
  localparam logic [2:0] ST_START  = DRV_START;
  localparam logic [2:0] ST_LOAD_X = DRV_LOAD_X;
  localparam logic [2:0] ST_GAP    = DRV_GAP;
  localparam logic [2:0] ST_LOAD_Y = DRV_LOAD_Y;
  localparam logic [2:0] ST_WAIT   = DRV_WAIT_DONE;
  localparam logic [2:0] ST_RESP   = DRV_RESP;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       accept;
  logic       rsvd_op;
  logic       timeout;
  logic       rearm;
  logic       enter_resp;

  assign accept     = (state_q == ST_IDLE) && bus.cmd_ready && bus.cmd_valid;
  assign rsvd_op    = (bus.cmd_op == OP_RSVD);
  assign enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
  // A timeout only counts when neither completion signal arrived with it.
  assign rearm      = (state_q == ST_WAIT) && timeout && !bus.w_error && !bus.w_ready;

`ifdef MDR_TIMEOUT_EN
  mdr_drv_watchdog #(
    .TO_CYC (TO_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .in_wait (state_q == ST_WAIT),
    .expired (timeout)
  );
`else
  // The limit only matters when the watchdog is built.
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC == 0);
  assign timeout       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = rsvd_op ? ST_RESP : ST_START;
      ST_START:  state_d = ST_LOAD_X;
      ST_LOAD_X: state_d = ST_GAP;
      ST_GAP:    state_d = ST_LOAD_Y;
      ST_LOAD_Y: state_d = ST_WAIT;
      ST_WAIT:   if (bus.w_error || bus.w_ready || timeout) state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bus.cmd_ready  <= 1'b0;
      bus.w_start    <= 1'b0;
      bus.w_load     <= 1'b0;
      bus.w_op       <= '0;
      bus.w_dataIn_X <= '0;
      bus.w_dataIn_Y <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_rem    <= '0;
      bus.rsp_status <= '0;
    end else begin
      state_q       <= state_d;
      bus.cmd_ready <= (state_d == ST_IDLE);
      bus.w_start   <= (state_d == ST_START) || rearm;
      bus.w_load    <= (state_d == ST_LOAD_X) || (state_d == ST_LOAD_Y);
      bus.rsp_valid <= (state_d == ST_RESP);

      // Operand bus: latched on accept, held through WAIT_DONE, zero otherwise.
      if ((state_q == ST_IDLE) && (state_d == ST_START)) begin
        bus.w_op       <= bus.cmd_op;
        bus.w_dataIn_X <= bus.cmd_x;
        bus.w_dataIn_Y <= (bus.cmd_op == SQRT) ? '0 : bus.cmd_y;
      end else if ((state_d == ST_IDLE) || (state_d == ST_RESP)) begin
        bus.w_op       <= '0;
        bus.w_dataIn_X <= '0;
        bus.w_dataIn_Y <= '0;
      end

      // Response payload is set once on RESP entry and held until handshake.
      if (enter_resp) begin
        if (state_q == ST_IDLE || rearm) begin
          bus.rsp_result <= '0;
          bus.rsp_rem    <= '0;
          bus.rsp_status <= RSP_TIMEOUT;
        end else if (bus.w_error) begin
          // Error wins over a simultaneous w_ready; MDR data is not captured.
          bus.rsp_result <= '0;
          bus.rsp_rem    <= '0;
          bus.rsp_status <= RSP_ERROR;
        end else begin
          bus.rsp_result <= bus.mdr_result;
          bus.rsp_rem    <= bus.mdr_rem;
          bus.rsp_status <= bus.w_ovf ? RSP_OVF : RSP_OK;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdr_cmd_driver.sv
// Directed bench for mdr_cmd_driver with a behavioural MDR model and a
// response scoreboard. Define MDR_TIMEOUT_EN to include the watchdog case.
module tb_mdr_cmd_driver;
  import pkg_system_mdr::*;

`ifdef MDR_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdr_cmd_driver_if #(.DW(16)) bus ();

  mdr_cmd_driver #(.DW(16), .TO_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic [1:0]  st;
    bit          chk;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_load = 0;

  // ---------------- MDR model ----------------
  int          mdl_mode = 0;  // 0 normal, 1 error+ready together, 2 never answers
  int          mdl_lat  = 5;
  int          loads;
  int          cnt;
  logic        armed;
  op_t         m_op;
  logic [15:0] m_x, m_y;

  function automatic logic [32:0] mdl_calc(input op_t op, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    int s;
    s = 0;
    case (op)
      MULT: begin
        p = 32'(x) * 32'(y);
        return {|p[31:16], 16'h0000, p[15:0]};
      end
      DIV:  return (y != 0) ? {1'b0, x % y, x / y} : 33'd0;
      SQRT: begin
        for (int i = 0; i < 256; i++) if (i * i <= int'(x)) s = i;
        return {1'b0, x - 16'(s * s), 16'(s)};
      end
      default: return 33'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      loads <= 0; armed <= 1'b0; cnt <= 0;
      m_op <= 2'b00; m_x <= 16'h0; m_y <= 16'h0;
      bus.w_ready <= 1'b0; bus.w_error <= 1'b0; bus.w_ovf <= 1'b0;
      bus.mdr_result <= 16'h0; bus.mdr_rem <= 16'h0;
    end else begin
      bus.w_ready <= 1'b0; bus.w_error <= 1'b0; bus.w_ovf <= 1'b0;
      if (bus.w_start) begin
        loads <= 0;
        m_op  <= bus.w_op;
      end else if (bus.w_load) begin
        loads <= loads + 1;
        if (loads == 0) m_x <= bus.w_dataIn_X;
        if (loads == 1) begin
          m_y <= bus.w_dataIn_Y;
          if (mdl_mode != 2) begin armed <= 1'b1; cnt <= mdl_lat; end
        end
      end
      if (armed) begin
        if (cnt == 0) begin
          armed <= 1'b0;
          bus.w_ready <= 1'b1;
          if (mdl_mode == 1) begin
            bus.w_error    <= 1'b1;
            bus.mdr_result <= 16'hDEAD;
            bus.mdr_rem    <= 16'hBEEF;
          end else begin
            {bus.w_ovf, bus.mdr_rem, bus.mdr_result} <= mdl_calc(m_op, m_x, m_y);
          end
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (bus.w_start) n_start <= n_start + 1;
    if (bus.w_load)  n_load  <= n_load + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [79:0] all_outs();
    return {bus.cmd_ready, bus.w_start, bus.w_load, bus.w_op, bus.w_dataIn_X,
            bus.w_dataIn_Y, bus.rsp_valid, bus.rsp_result, bus.rsp_rem, bus.rsp_status};
  endfunction

  task automatic send_cmd(input op_t op, input logic [15:0] x, input logic [15:0] y);
    int g = 0;
    while (bus.cmd_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    check("cmd_ready_before_send", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Called in the START cycle; ends in the LOAD_Y cycle.
  task automatic walk_load(input op_t op, input logic [15:0] x, input logic [15:0] ey);
    check("start_pulse",  {bus.w_start, bus.w_load, bus.cmd_ready}, 3'b100);
    check("start_op",     bus.w_op, op);
    @(negedge clk);
    check("loadx_strobe", {bus.w_start, bus.w_load}, 2'b01);
    check("loadx_data",   bus.w_dataIn_X, x);
    @(negedge clk);
    check("gap_strobe",   {bus.w_start, bus.w_load}, 2'b00);
    @(negedge clk);
    check("loady_strobe", {bus.w_start, bus.w_load}, 2'b01);
    check("loady_data",   bus.w_dataIn_Y, ey);
    check("loady_op",     bus.w_op, op);
  endtask

  task automatic wait_rsp(input string tag, input int hold);
    int g = 0;
    exp_t e;
    logic [15:0] r0, m0;
    while (bus.rsp_valid !== 1'b1 && g < 200) begin @(negedge clk); g++; end
    check({tag, "_valid"}, bus.rsp_valid, 1);
    check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1);
    if (bus.rsp_valid !== 1'b1 || exp_q.size() == 0) return;
    e = exp_q.pop_front();
    if (e.chk) begin
      check({tag, "_result"}, bus.rsp_result, e.res);
      check({tag, "_rem"},    bus.rsp_rem,    e.rem);
    end else begin
      check({tag, "_no_capture"}, (bus.rsp_result !== 16'hDEAD) && (bus.rsp_rem !== 16'hBEEF), 1);
    end
    check({tag, "_status"}, bus.rsp_status, e.st);
    check({tag, "_strobes_idle"}, {bus.w_load, bus.cmd_ready}, 2'b00);
    r0 = bus.rsp_result; m0 = bus.rsp_rem;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {bus.rsp_valid, bus.cmd_ready}, 2'b10);
      check({tag, "_hold_data"},  {bus.rsp_result, bus.rsp_rem, bus.rsp_status}, {r0, m0, e.st});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_after_hs"}, {bus.rsp_valid, bus.cmd_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed sequence ----------------
  int s0, l0;
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_x = 16'h0; bus.cmd_y = 16'h0;
    bus.rsp_ready = 1'b0;

    // reset
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 80'h0);
    rst = 1'b0;
    #1 check("first_edge_cmd_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1);

    // MULT 7*9
    mdl_mode = 0; mdl_lat = 5;
    exp_q.push_back('{16'd63, 16'd0, 2'b00, 1'b1});
    send_cmd(MULT, 16'd7, 16'd9);
    walk_load(MULT, 16'd7, 16'd9);
    @(negedge clk);
    check("wait_strobes_low", {bus.w_start, bus.w_load, bus.rsp_valid}, 3'b000);
    wait_rsp("mult", 0);

    // DIV 100/7 with a stalled sink
    exp_q.push_back('{16'd14, 16'd2, 2'b00, 1'b1});
    send_cmd(DIV, 16'd100, 16'd7);
    walk_load(DIV, 16'd100, 16'd7);
    wait_rsp("div", 3);

    // MULT overflow
    exp_q.push_back('{16'd24464, 16'd0, 2'b10, 1'b1});
    send_cmd(MULT, 16'd300, 16'd300);
    walk_load(MULT, 16'd300, 16'd300);
    wait_rsp("ovf", 0);

    // DIV by zero: error and ready in the same cycle
    mdl_mode = 1; mdl_lat = 2;
    exp_q.push_back('{16'd0, 16'd0, 2'b01, 1'b0});
    send_cmd(DIV, 16'd5, 16'd0);
    walk_load(DIV, 16'd5, 16'd0);
    wait_rsp("err", 1);
    mdl_mode = 0;

    // reserved op: MDR untouched
    s0 = n_start; l0 = n_load;
    exp_q.push_back('{16'd0, 16'd0, 2'b11, 1'b1});
    send_cmd(OP_RSVD, 16'h1111, 16'h2222);
    check("rsvd_resp_next_cycle", {bus.rsp_valid, bus.rsp_status}, 3'b111);
    check("rsvd_no_strobe", {bus.w_start, bus.w_load}, 2'b00);
    wait_rsp("rsvd", 0);
    check("rsvd_start_count", n_start, s0);
    check("rsvd_load_count",  n_load,  l0);

    // reset in WAIT_DONE
    mdl_lat = 20;
    exp_q.push_back('{16'd15, 16'd0, 2'b00, 1'b1});
    send_cmd(MULT, 16'd3, 16'd5);
    walk_load(MULT, 16'd3, 16'd5);
    @(negedge clk);
    check("wait_x_held", bus.w_dataIn_X, 16'd3);
    #2 rst = 1'b1;
    #1 check("rst_async_outs", all_outs(), 80'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release_ready_low", bus.cmd_ready, 0);
    @(negedge clk);
    check("rst_release_ready", {bus.cmd_ready, bus.rsp_valid}, 2'b10);
    repeat (25) @(negedge clk);
    check("aborted_no_resp", bus.rsp_valid, 0);

    // SQRT after reset; Y bus forced to zero
    mdl_lat = 3;
    exp_q.push_back('{16'd12, 16'd0, 2'b00, 1'b1});
    send_cmd(SQRT, 16'd144, 16'h1234);
    walk_load(SQRT, 16'd144, 16'd0);
    wait_rsp("sqrt", 0);

`ifdef MDR_TIMEOUT_EN
    // MDR never answers
    mdl_mode = 2;
    s0 = n_start;
    exp_q.push_back('{16'd0, 16'd0, 2'b11, 1'b1});
    send_cmd(MULT, 16'd2, 16'd2);
    walk_load(MULT, 16'd2, 16'd2);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("to_still_waiting", bus.rsp_valid, 0);
    end
    @(negedge clk);
    check("to_resp_entry", {bus.rsp_valid, bus.w_start, bus.rsp_status}, 4'b1111);
    wait_rsp("timeout", 1);
    check("to_start_count", n_start, s0 + 2);
    mdl_mode = 0;
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
